distributed_fifo_ctrl: RTL



---
 rtl/distributed_fifo_pkg.sv | 24 ++
 rtl/distributed_fifo_out_stage.sv | 77 +++++++
 rtl/distributed_fifo_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/distributed_fifo_pkg.sv
// Shared types and sizing helpers for the distributed-RAM FIFO controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: out_state_t (prefetch-register state), fifo_depth(), fifo_cnt_w().
package distributed_fifo_pkg;

  // State of the one-entry prefetch register that feeds rd_data.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_t;

  // RAM depth for a given address width.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Width of the occupancy counters: must hold the RAM depth plus the
  // prefetch word (2**addr_width + 1), which fits in addr_width+1 bits.
  function automatic int fifo_cnt_w(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/distributed_fifo_out_stage.sv
// Prefetch output stage: holds the head word so reads are first-word-fall-through.
// Latency: a word present in the RAM is loaded on the next edge; rd_data/rd_valid are registered.
// Backpressure: i_rd_en pops the head; a pop with nothing loaded is ignored.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_flush           synchronous clear (beats i_rd_en)
//   i_rd_en           consumer pop request
//   i_ram_nonempty    RAM holds at least one word (from registered count)
//   i_ram_rd_data     combinational RAM read data at the read pointer
//   o_ld              load strobe: RAM head moves into the register this cycle
//   o_rd_valid        register holds a valid word
//   o_rd_data         register contents
module distributed_fifo_out_stage
  import distributed_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_rd_en,
  input  logic                  i_ram_nonempty,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
  output logic                  o_ld,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  out_state_t            r_state;
  out_state_t            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OUT_EMPTY;
    end else if (i_flush) begin
      r_state <= OUT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ld        = 1'b0;
    // Refill whenever the register is free or being popped; flush suppresses
    // the load so pointer/count updates are blocked too.
    if (!i_flush && i_ram_nonempty && ((r_state == OUT_EMPTY) || i_rd_en)) begin
      o_ld = 1'b1;
    end
    case (r_state)
      OUT_EMPTY: begin
        if (o_ld) w_state_nxt = OUT_VALID;
      end
      OUT_VALID: begin
        if (o_ld)         w_state_nxt = OUT_VALID;
        else if (i_rd_en) w_state_nxt = OUT_EMPTY;
      end
      default: w_state_nxt = OUT_EMPTY;
    endcase
  end

  // Data holds its last value when the head is popped with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_flush) begin
      r_rd_data <= '0;
    end else if (o_ld) begin
      r_rd_data <= i_ram_rd_data;
    end
  end

  assign o_rd_valid = (r_state == OUT_VALID);
  assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/distributed_fifo_ctrl.sv
// Single-clock FIFO controller driving an external distributed SDP RAM (unregistered read).
// Latency: write at edge E into an empty FIFO is visible on rd_data after edge E+1; no bypass.
// Backpressure: full blocks writes (dropped); pops with rd_valid=0 are ignored.
// Ports: clk, rst_n, flush; write side wr_en/wr_data/full/almost_full;
//   read side rd_en/rd_data/rd_valid/almost_empty/data_count;
//   RAM side ram_wr_en/ram_wr_addr/ram_wr_data/ram_rd_addr/ram_rd_data.
// Optional: define DISTRIBUTED_FIFO_ERR_FLAG_EN to add sticky overflow/underflow outputs.
module distributed_fifo_ctrl
  import distributed_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH       = 4,
  parameter int DATA_WIDTH       = 8,
  parameter int ALMOST_FULL_NUM  = 14,
  parameter int ALMOST_EMPTY_NUM = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
`ifdef DISTRIBUTED_FIFO_ERR_FLAG_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int CNT_W = fifo_cnt_w(ADDR_WIDTH);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_THR    = CNT_W'(ALMOST_FULL_NUM);
  localparam logic [CNT_W-1:0] AE_THR    = CNT_W'(ALMOST_EMPTY_NUM);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_ram_count;

  logic                  w_full;
  logic                  w_we;
  logic                  w_ld;
  logic                  w_rd_valid;
  logic [CNT_W-1:0]      w_data_count;

  // Full comes from the registered count only, so a pop in a full cycle
  // frees the slot for writes one cycle later.
  assign w_full = (r_ram_count == DEPTH_CNT);
  assign w_we   = wr_en & ~w_full;

  distributed_fifo_out_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_stage (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_flush        (flush),
    .i_rd_en        (rd_en),
    .i_ram_nonempty (r_ram_count != '0),
    .i_ram_rd_data  (ram_rd_data),
    .o_ld           (w_ld),
    .o_rd_valid     (w_rd_valid),
    .o_rd_data      (rd_data)
  );

  // Pointers wrap naturally at 2**ADDR_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_count <= '0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_count <= '0;
    end else begin
      if (w_we) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_ld) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      r_ram_count <= r_ram_count + CNT_W'(w_we) - CNT_W'(w_ld);
    end
  end

  assign w_data_count = r_ram_count + CNT_W'(w_rd_valid);

  assign full         = w_full;
  assign almost_full  = (r_ram_count >= AF_THR);
  assign almost_empty = (w_data_count <= AE_THR);
  assign data_count   = w_data_count;
  assign rd_valid     = w_rd_valid;

  assign ram_wr_en    = w_we & ~flush;
  assign ram_wr_addr  = r_wr_ptr;
  assign ram_wr_data  = wr_data;
  assign ram_rd_addr  = r_rd_ptr;

`ifdef DISTRIBUTED_FIFO_ERR_FLAG_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en & w_full)      r_overflow  <= 1'b1;
      if (rd_en & ~w_rd_valid) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule
